hash_sched: RTL

Round-robin scheduler that shares one `hash_function` core among `N_REQ` requesters. It accepts one 32-bit message/IV pair per transaction over a valid/ready handshake and drives the core's `start`, `m` and `IV` inputs. It captures the digest on `done` and returns it to the granted requester over a valid/ready response channel. A watchdog converts a hung core into an error response.

---
 rtl/hash_pkg.sv | 15 +
 rtl/hash_sched_rr_picker.sv | 31 +++
 rtl/hash_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/hash_pkg.sv
// Shared types and constants for the hash core scheduler.
// Imported by the scheduler top and its sub-modules.
package hash_pkg;

  localparam int WORD_W = 32;
  localparam int BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

endpackage

// File: rtl/hash_sched_rr_picker.sv
// Combinational round-robin picker: first set request
// searching upward from last_grant+1, with wrap.
module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [GW-1:0]    idx,
  output logic             any
);

  logic [GW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = GW'((int'(last_grant) + 1 + i) % N_REQ);
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = j;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_sched.sv
// Round-robin scheduler sharing one hash core among N_REQ
// requesters, with a watchdog that turns a hung core into an error.
module hash_sched
  import hash_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 64,
  localparam int GW      = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*WORD_W-1:0] req_msg,
  input  logic [N_REQ*WORD_W-1:0] req_iv,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [WORD_W-1:0]       rsp_digest,
  output logic                    rsp_error,
  output logic                    core_start,
  output logic [WORD_W-1:0]       core_m,
  output logic [WORD_W-1:0]       core_iv,
  input  logic [WORD_W-1:0]       core_d,
  input  logic                    core_done,
  output logic                    busy,
  output logic [GW-1:0]           grant_id
);

  localparam int WDW = $clog2(TIMEOUT);

  sched_state_t      state_q, state_d;
  logic [GW-1:0]     last_q, grant_q, pick_idx;
  logic [N_REQ-1:0]  pick_oh;
  logic              pick_any;
  logic [WORD_W-1:0] msg_q, iv_q, digest_q;
  logic              err_q;
  logic [WDW-1:0]    wd_q;
  logic              wd_exp;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .grant      (pick_oh),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  assign wd_exp     = (wd_q == WDW'(TIMEOUT - 1));
  assign busy       = (state_q != IDLE);
  assign core_m     = msg_q;
  assign core_iv    = iv_q;
  assign grant_id   = grant_q;
  assign rsp_digest = (state_q == RESP) ? digest_q : '0;
  assign rsp_error  = (state_q == RESP) && err_q;

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_oh;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (core_done || wd_exp) state_d = RESP;
      end
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= GW'(N_REQ - 1);
      grant_q  <= '0;
      msg_q    <= '0;
      iv_q     <= '0;
      digest_q <= '0;
      err_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            msg_q   <= req_msg[pick_idx*WORD_W +: WORD_W];
            iv_q    <= req_iv[pick_idx*WORD_W +: WORD_W];
          end
        end
        ISSUE: wd_q <= '0;
        WAIT: begin
          // done wins over a watchdog expiry in the same cycle
          if (core_done) begin
            digest_q <= core_d;
            err_q    <= 1'b0;
          end else if (wd_exp) begin
            digest_q <= '0;
            err_q    <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[grant_q]) last_q <= grant_q;
        end
        default: ;
      endcase
    end
  end

endmodule
